// File: rtl/i2s_tx_if.sv
// Sample-pair handshake and I2S wire bundle between a sample source and the i2s_tx master.
// The master modport drives samples; the slave modport (the transmitter) drives the I2S wires.
interface i2s_tx_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] left_in;
  logic [DATA_WIDTH-1:0] right_in;
  logic                  in_valid;
  logic                  in_ready;
  logic                  bclk;
  logic                  ws;
  logic                  sdata;
  logic                  frame_start;
  logic                  underrun;

  modport master (
    output left_in, right_in, in_valid,
    input  in_ready, bclk, ws, sdata, frame_start, underrun
  );

  modport slave (
    input  left_in, right_in, in_valid,
    output in_ready, bclk, ws, sdata, frame_start, underrun
  );
endinterface

// File: rtl/i2s_tx.sv
// I2S master transmitter: derives BCLK/WS from clk and shifts 24-bit stereo pairs out MSB-first,
// fed through a single-entry holding buffer that is committed to the wire once per frame.
module i2s_tx #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int BCLK_HALF  = 4,
  parameter int DATA_DELAY = 1
) (
  input  logic    clk,
  input  logic    rst,
  i2s_tx_if.slave i2s
);
  localparam int FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int IDX_W      = $clog2(FRAME_BITS);
  localparam int HC_W       = $clog2(BCLK_HALF);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_BITS - 1);
  localparam logic [IDX_W-1:0] SLOT_IDX  = IDX_W'(SLOT_WIDTH);
  localparam logic [IDX_W-1:0] DELAY_IDX = IDX_W'(DATA_DELAY);
  localparam logic [IDX_W-1:0] DW_IDX    = IDX_W'(DATA_WIDTH);
  localparam logic [HC_W-1:0]  HALF_LAST = HC_W'(BCLK_HALF - 1);

  logic [HC_W-1:0]       r_half_cnt;
  logic                  r_bclk;
  logic                  r_ws;
  logic                  r_sdata;
  logic                  r_frame_start;
  logic                  r_underrun;
  logic [IDX_W-1:0]      r_bit_idx;
  logic                  r_hold_full;
  logic [DATA_WIDTH-1:0] r_hold_l;
  logic [DATA_WIDTH-1:0] r_hold_r;
  logic [DATA_WIDTH-1:0] r_left_sr;
  logic [DATA_WIDTH-1:0] r_right_sr;

  logic                  w_half_wrap;
  logic                  w_bit_fall;
  logic                  w_frame;
  logic                  w_accept;
  logic                  w_hold_release;
  logic [IDX_W-1:0]      w_idx_next;
  logic                  w_ws_next;
  logic [IDX_W-1:0]      w_pos;
  logic [IDX_W-1:0]      w_off;
  logic                  w_in_data;
  logic [DATA_WIDTH-1:0] w_left_next;
  logic [DATA_WIDTH-1:0] w_right_next;
  logic [DATA_WIDTH-1:0] w_sample;
  logic [DATA_WIDTH-1:0] w_shifted;
  logic                  w_sdata_next;

  assign w_half_wrap = (r_half_cnt == HALF_LAST);
  assign w_bit_fall  = w_half_wrap & r_bclk;
  assign w_idx_next  = (r_bit_idx == LAST_IDX) ? '0 : r_bit_idx + 1'b1;
  assign w_frame     = w_bit_fall & (r_bit_idx == LAST_IDX);
  assign w_accept    = i2s.in_valid & ~r_hold_full;
  // Buffer is released one cycle after a loading frame_start so in_ready rises after the pulse.
  assign w_hold_release = r_frame_start & ~r_underrun;

  // Shift registers seen by the bit being launched, so DATA_DELAY=0 can emit the fresh MSB at once.
  assign w_left_next  = w_frame ? (r_hold_full ? r_hold_l : '0) : r_left_sr;
  assign w_right_next = w_frame ? (r_hold_full ? r_hold_r : '0) : r_right_sr;

  // Offsets before the data window wrap to large values, so one compare covers both edges.
  assign w_ws_next    = (w_idx_next >= SLOT_IDX);
  assign w_pos        = w_ws_next ? (w_idx_next - SLOT_IDX) : w_idx_next;
  assign w_off        = w_pos - DELAY_IDX;
  assign w_in_data    = (w_off < DW_IDX);
  assign w_sample     = w_ws_next ? w_right_next : w_left_next;
  assign w_shifted    = w_sample << w_off;
  assign w_sdata_next = w_in_data & w_shifted[DATA_WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_half_cnt    <= '0;
      r_bclk        <= 1'b0;
      r_ws          <= 1'b1;
      r_sdata       <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      r_bit_idx     <= LAST_IDX;
      r_hold_full   <= 1'b0;
      r_hold_l      <= '0;
      r_hold_r      <= '0;
      r_left_sr     <= '0;
      r_right_sr    <= '0;
    end else begin
      r_half_cnt    <= w_half_wrap ? '0 : r_half_cnt + 1'b1;
      r_frame_start <= w_frame;
      r_underrun    <= w_frame & ~r_hold_full;
      if (w_half_wrap) begin
        r_bclk <= ~r_bclk;
      end
      if (w_bit_fall) begin
        r_bit_idx <= w_idx_next;
        r_ws      <= w_ws_next;
        r_sdata   <= w_sdata_next;
      end
      if (w_frame) begin
        r_left_sr  <= w_left_next;
        r_right_sr <= w_right_next;
      end
      if (w_accept) begin
        r_hold_full <= 1'b1;
        r_hold_l    <= i2s.left_in;
        r_hold_r    <= i2s.right_in;
      end else if (w_hold_release) begin
        r_hold_full <= 1'b0;
      end
    end
  end

  assign i2s.in_ready    = ~r_hold_full;
  assign i2s.bclk        = r_bclk;
  assign i2s.ws          = r_ws;
  assign i2s.sdata       = r_sdata;
  assign i2s.frame_start = r_frame_start;
  assign i2s.underrun    = r_underrun;
endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: a standard-I2S instance (DATA_DELAY=1, BCLK_HALF=4) and a
// left-justified fast instance (DATA_DELAY=0, BCLK_HALF=2), checked with immediate assertions.
module tb_i2s_tx;
  logic clk;
  logic rst;

  i2s_tx_if #(.DATA_WIDTH(24)) bus0 ();
  i2s_tx_if #(.DATA_WIDTH(24)) bus1 ();

  i2s_tx #(.DATA_WIDTH(24), .SLOT_WIDTH(32), .BCLK_HALF(4), .DATA_DELAY(1)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .i2s (bus0)
  );

  i2s_tx #(.DATA_WIDTH(24), .SLOT_WIDTH(32), .BCLK_HALF(2), .DATA_DELAY(0)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .i2s (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_err    = 0;
  int accepts  = 0;
  logic [23:0] q_l[$];
  logic [23:0] q_r[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected 64-bit frame as seen on bclk rises, position 0 of the left slot first.
  function automatic logic [63:0] mk_frame(input logic [23:0] l, input logic [23:0] r);
    return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
  endfunction

  task automatic drive0();
    if (q_l.size() > 0) begin
      bus0.in_valid = 1'b1;
      bus0.left_in  = q_l[0];
      bus0.right_in = q_r[0];
    end else begin
      bus0.in_valid = 1'b0;
    end
  endtask

  task automatic step0();
    logic acc;
    acc = bus0.in_valid && bus0.in_ready && !rst;
    @(negedge clk);
    if (acc) begin
      accepts++;
      void'(q_l.pop_front());
      void'(q_r.pop_front());
    end
    drive0();
  endtask

  task automatic run_frame0(output logic [63:0] bits, output int period, output int lows,
                            output int ones);
    int   nb;
    logic prev;
    bits = '0; nb = 0; period = 0; lows = 0; ones = 0;
    prev = bus0.bclk;
    do begin
      if (!bus0.ws) lows++;
      if (bus0.sdata) ones++;
      period++;
      step0();
      if (bus0.bclk && !prev && nb < 64) begin
        bits[63-nb] = bus0.sdata;
        nb++;
      end
      prev = bus0.bclk;
    end while (!bus0.frame_start && period < 2000);
    chk("dut0_frame_start_seen", 64'(bus0.frame_start), 64'd1);
  endtask

  task automatic run_frame1(output logic [63:0] bits, output int period);
    int   nb;
    logic prev;
    bits = '0; nb = 0; period = 0;
    prev = bus1.bclk;
    do begin
      period++;
      @(negedge clk);
      if (bus1.bclk && !prev && nb < 64) begin
        bits[63-nb] = bus1.sdata;
        nb++;
      end
      prev = bus1.bclk;
    end while (!bus1.frame_start && period < 1000);
    chk("dut1_frame_start_seen", 64'(bus1.frame_start), 64'd1);
  endtask

  initial begin
    logic [63:0] bits;
    int period, lows, ones;

    rst = 1'b1;
    bus0.in_valid = 1'b0; bus0.left_in = '0; bus0.right_in = '0;
    bus1.in_valid = 1'b0; bus1.left_in = '0; bus1.right_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_bclk",        64'(bus0.bclk),        64'd0);
    chk("rst_ws",          64'(bus0.ws),          64'd1);
    chk("rst_sdata",       64'(bus0.sdata),       64'd0);
    chk("rst_frame_start", 64'(bus0.frame_start), 64'd0);
    chk("rst_underrun",    64'(bus0.underrun),    64'd0);
    chk("rst_in_ready",    64'(bus0.in_ready),    64'd1);

    // Idle framing with no samples offered.
    rst = 1'b0;
    run_frame0(bits, period, lows, ones);
    chk("t1_first_fs_cycle", 64'(period), 64'd8);
    chk("t1_first_underrun", 64'(bus0.underrun), 64'd1);
    chk("t1_ws_low_at_fs",   64'(bus0.ws), 64'd0);
    run_frame0(bits, period, lows, ones);
    chk("t1_frame_period",   64'(period), 64'd512);
    chk("t1_ws_low_cycles",  64'(lows),   64'd256);
    chk("t1_sdata_ones",     64'(ones),   64'd0);
    chk("t1_frame_bits",     bits,        64'd0);
    chk("t1_second_underrun", 64'(bus0.underrun), 64'd1);

    // Pair offered before the first boundary.
    rst = 1'b1;
    accepts = 0;
    @(negedge clk);
    q_l.push_back(24'hA5A5A5); q_r.push_back(24'h5A5A5A);
    drive0();
    @(negedge clk);
    rst = 1'b0;
    run_frame0(bits, period, lows, ones);
    chk("t2_first_fs_cycle", 64'(period), 64'd8);
    chk("t2_no_underrun",    64'(bus0.underrun), 64'd0);
    chk("t2_accepts",        64'(accepts), 64'd1);
    run_frame0(bits, period, lows, ones);
    chk("t2_frame_bits",     bits, mk_frame(24'hA5A5A5, 24'h5A5A5A));
    chk("t2_next_underrun",  64'(bus0.underrun), 64'd1);

    // Continuous stream, in_valid held high.
    q_l.push_back(24'h000001); q_r.push_back(24'h000002);
    q_l.push_back(24'h000003); q_r.push_back(24'h000004);
    q_l.push_back(24'h000005); q_r.push_back(24'h000006);
    drive0();
    run_frame0(bits, period, lows, ones);
    chk("t3a_bits_zero",   bits, 64'd0);
    chk("t3a_underrun",    64'(bus0.underrun), 64'd0);
    chk("t3a_ready_at_fs", 64'(bus0.in_ready), 64'd0);
    chk("t3a_accepts",     64'(accepts), 64'd2);
    step0();
    chk("t3a_ready_after_fs", 64'(bus0.in_ready), 64'd1);
    run_frame0(bits, period, lows, ones);
    chk("t3b_bits",        bits, mk_frame(24'h000001, 24'h000002));
    chk("t3b_underrun",    64'(bus0.underrun), 64'd0);
    chk("t3b_ready_at_fs", 64'(bus0.in_ready), 64'd0);
    chk("t3b_accepts",     64'(accepts), 64'd3);
    step0();
    chk("t3b_ready_after_fs", 64'(bus0.in_ready), 64'd1);
    run_frame0(bits, period, lows, ones);
    chk("t3c_bits",        bits, mk_frame(24'h000003, 24'h000004));
    chk("t3c_underrun",    64'(bus0.underrun), 64'd0);
    chk("t3c_ready_at_fs", 64'(bus0.in_ready), 64'd0);
    chk("t3c_accepts",     64'(accepts), 64'd4);
    step0();
    chk("t3c_ready_after_fs", 64'(bus0.in_ready), 64'd1);
    run_frame0(bits, period, lows, ones);
    chk("t3d_bits",        bits, mk_frame(24'h000005, 24'h000006));
    chk("t3d_underrun",    64'(bus0.underrun), 64'd1);
    chk("t3d_accepts",     64'(accepts), 64'd4);

    // Full-scale extremes, sign bit first.
    q_l.push_back(24'h800000); q_r.push_back(24'h7FFFFF);
    drive0();
    run_frame0(bits, period, lows, ones);
    chk("t4_pre_underrun", 64'(bus0.underrun), 64'd0);
    run_frame0(bits, period, lows, ones);
    chk("t4_bits",         bits, mk_frame(24'h800000, 24'h7FFFFF));
    chk("t4_underrun",     64'(bus0.underrun), 64'd1);

    // Reset mid right slot with the holding buffer full.
    q_l.push_back(24'h123456); q_r.push_back(24'h654321);
    drive0();
    run_frame0(bits, period, lows, ones);
    chk("t5_load_no_underrun", 64'(bus0.underrun), 64'd0);
    q_l.push_back(24'h0F0F0F); q_r.push_back(24'hF0F0F0);
    drive0();
    repeat (300) step0();
    chk("t5_pre_ws_right",  64'(bus0.ws),       64'd1);
    chk("t5_pre_buf_full",  64'(bus0.in_ready), 64'd0);
    rst = 1'b1;
    #1;
    chk("t5_rst_bclk",      64'(bus0.bclk),     64'd0);
    chk("t5_rst_ws",        64'(bus0.ws),       64'd1);
    chk("t5_rst_sdata",     64'(bus0.sdata),    64'd0);
    chk("t5_rst_in_ready",  64'(bus0.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    run_frame0(bits, period, lows, ones);
    chk("t5_first_fs_cycle", 64'(period), 64'd8);
    chk("t5_held_discarded", 64'(bus0.underrun), 64'd1);

    // Left-justified, fast BCLK instance.
    rst = 1'b1;
    bus1.left_in  = 24'hFFFFFF;
    bus1.right_in = 24'h000000;
    bus1.in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_frame1(bits, period);
    chk("t6_first_fs_cycle", 64'(period),         64'd4);
    chk("t6_ws_at_fs",       64'(bus1.ws),        64'd0);
    chk("t6_msb_at_fs",      64'(bus1.sdata),     64'd1);
    chk("t6_no_underrun",    64'(bus1.underrun),  64'd0);
    bus1.in_valid = 1'b0;
    run_frame1(bits, period);
    chk("t6_frame_bits",     bits,                {24'hFFFFFF, 40'd0});
    chk("t6_frame_period",   64'(period),         64'd256);
    chk("t6_next_underrun",  64'(bus1.underrun),  64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
